// File: rtl/mac_frame_engine.sv
// Ethernet test frame generator (RX master) and loopback pattern checker (TX slave).
// Header plus incrementing payload, with configurable length, frame count and gap.
module mac_frame_engine #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter logic [47:0] SRC_MAC     = 48'h000000000002,
    parameter logic [47:0] DST_MAC     = 48'h000000000001,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          FRAME_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           cfg_payload_len,
    input  logic [15:0]           cfg_num_frames,
    output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_rx_axis_tkeep,
    output logic                  m_rx_axis_tvalid,
    output logic                  m_rx_axis_tlast,
    input  logic                  m_rx_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_tx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tx_axis_tkeep,
    input  logic                  s_tx_axis_tvalid,
    input  logic                  s_tx_axis_tlast,
    output logic                  s_tx_axis_tready,
    output logic [31:0]           gen_frame_count,
    output logic [31:0]           chk_frame_count,
    output logic [31:0]           chk_error_count,
    output logic                  busy,
    output logic                  done
);

    localparam logic [15:0] P_MIN    = 16'(MIN_PAYLOAD);
    localparam logic [15:0] P_MAX    = 16'(MAX_PAYLOAD);
    localparam logic [15:0] KW16     = 16'(KEEP_WIDTH);
    localparam logic [31:0] KW32     = 32'(KEEP_WIDTH);
    localparam logic [15:0] GAP_LAST = (FRAME_GAP > 0) ? 16'(FRAME_GAP - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    function automatic logic [7:0] pat_byte(input logic [31:0] b,
                                            input logic [15:0] p,
                                            input logic [7:0]  idx);
        logic [2:0] ix;
        logic [7:0] r;
        ix = '0;
        r  = '0;
        if (b < 32'd6) begin
            ix = 3'(32'd5 - b);
            r  = DST_MAC[8*ix +: 8];
        end else if (b < 32'd12) begin
            ix = 3'(32'd11 - b);
            r  = SRC_MAC[8*ix +: 8];
        end else if (b == 32'd12) begin
            r = p[15:8];
        end else if (b == 32'd13) begin
            r = p[7:0];
        end else begin
            r = b[7:0] - 8'd14 + idx;
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [15:0] off,
                                                        input logic [15:0] p,
                                                        input logic [7:0]  idx);
        logic [DATA_WIDTH-1:0] d;
        logic [31:0]           len;
        d   = '0;
        len = 32'd14 + {16'd0, p};
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if ({16'd0, off} + 32'(k) < len)
                d[8*k +: 8] = pat_byte({16'd0, off} + 32'(k), p, idx);
        end
        return d;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [15:0] off,
                                                        input logic [15:0] p);
        logic [KEEP_WIDTH-1:0] kp;
        kp = '0;
        for (int k = 0; k < KEEP_WIDTH; k++)
            kp[k] = ({16'd0, off} + 32'(k) < 32'd14 + {16'd0, p});
        return kp;
    endfunction

    state_t      state, state_n;
    logic [15:0] off, plen, fidx, gap_cnt;
    logic [15:0] ld_off, ld_p, ld_idx, fidx_n, gap_n, clamp_len;
    logic        ld, vld_n, gen_inc, accept;

    assign accept    = m_rx_axis_tvalid && m_rx_axis_tready;
    assign clamp_len = (cfg_payload_len < P_MIN) ? P_MIN :
                       (cfg_payload_len > P_MAX) ? P_MAX : cfg_payload_len;
    assign done      = (state == DONE);
    assign busy      = (state == SEND) || (state == GAP);

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        ld_off  = off + KW16;
        ld_p    = plen;
        ld_idx  = fidx;
        vld_n   = m_rx_axis_tvalid;
        gap_n   = gap_cnt;
        fidx_n  = fidx;
        gen_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    ld      = 1'b1;
                    ld_off  = '0;
                    ld_p    = clamp_len;
                    vld_n   = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (accept && !m_rx_axis_tlast) begin
                    ld = 1'b1;
                end else if (accept) begin
                    gen_inc = 1'b1;
                    fidx_n  = fidx + 16'd1;
                    vld_n   = 1'b0;
                    if (cfg_num_frames != 16'd0 && fidx_n == cfg_num_frames) begin
                        state_n = DONE;
                    end else if (!enable) begin
                        state_n = IDLE;
                    end else if (FRAME_GAP == 0) begin
                        // back-to-back frames: next beat 0 on the same edge
                        ld     = 1'b1;
                        ld_off = '0;
                        ld_p   = clamp_len;
                        ld_idx = fidx_n;
                        vld_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                        gap_n   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt != GAP_LAST) begin
                    gap_n = gap_cnt + 16'd1;
                end else if (enable) begin
                    ld      = 1'b1;
                    ld_off  = '0;
                    ld_p    = clamp_len;
                    vld_n   = 1'b1;
                    state_n = SEND;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                vld_n = 1'b0;
                if (!enable) begin
                    state_n = IDLE;
                    fidx_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            off              <= '0;
            plen             <= '0;
            fidx             <= '0;
            gap_cnt          <= '0;
            gen_frame_count  <= '0;
            m_rx_axis_tvalid <= 1'b0;
            m_rx_axis_tdata  <= '0;
            m_rx_axis_tkeep  <= '0;
            m_rx_axis_tlast  <= 1'b0;
        end else begin
            state            <= state_n;
            gap_cnt          <= gap_n;
            fidx             <= fidx_n;
            m_rx_axis_tvalid <= vld_n;
            if (gen_inc)
                gen_frame_count <= gen_frame_count + 32'd1;
            if (ld) begin
                off             <= ld_off;
                plen            <= ld_p;
                m_rx_axis_tdata <= beat_data(ld_off, ld_p, ld_idx[7:0]);
                m_rx_axis_tkeep <= beat_keep(ld_off, ld_p);
                m_rx_axis_tlast <= ({16'd0, ld_off} + KW32 >= 32'd14 + {16'd0, ld_p});
            end else if (!vld_n) begin
                m_rx_axis_tdata <= '0;
                m_rx_axis_tkeep <= '0;
                m_rx_axis_tlast <= 1'b0;
            end
        end
    end

    logic [31:0] chk_off, nbytes, cnt, exp_len;
    logic [15:0] rx_p, eff_p;
    logic [7:0]  chk_idx;
    logic        err_acc, beat_err, chk_acc;

    assign chk_acc = s_tx_axis_tvalid && s_tx_axis_tready;

    // length field is taken from the received header, unclamped
    always_comb begin
        eff_p    = rx_p;
        beat_err = 1'b0;
        nbytes   = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (s_tx_axis_tkeep[k]) begin
                nbytes = nbytes + 32'd1;
                if (chk_off + 32'(k) == 32'd12)
                    eff_p[15:8] = s_tx_axis_tdata[8*k +: 8];
                else if (chk_off + 32'(k) == 32'd13)
                    eff_p[7:0] = s_tx_axis_tdata[8*k +: 8];
                else if (s_tx_axis_tdata[8*k +: 8] !=
                         pat_byte(chk_off + 32'(k), 16'd0, chk_idx))
                    beat_err = 1'b1;
            end
        end
        cnt     = chk_off + nbytes;
        exp_len = 32'd14 + {16'd0, eff_p};
        if (!s_tx_axis_tlast && s_tx_axis_tkeep != '1)
            beat_err = 1'b1;
        if (s_tx_axis_tlast && cnt != exp_len)
            beat_err = 1'b1;
        if (!s_tx_axis_tlast && cnt > exp_len)
            beat_err = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_tx_axis_tready <= 1'b0;
            chk_off          <= '0;
            rx_p             <= '0;
            chk_idx          <= '0;
            err_acc          <= 1'b0;
            chk_frame_count  <= '0;
            chk_error_count  <= '0;
        end else begin
            s_tx_axis_tready <= 1'b1;
            if (chk_acc && s_tx_axis_tlast) begin
                chk_frame_count <= chk_frame_count + 32'd1;
                if (err_acc || beat_err)
                    chk_error_count <= chk_error_count + 32'd1;
                chk_off <= '0;
                rx_p    <= '0;
                err_acc <= 1'b0;
                chk_idx <= chk_idx + 8'd1;
            end else if (chk_acc) begin
                chk_off <= cnt;
                rx_p    <= eff_p;
                err_acc <= err_acc || beat_err;
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_engine.sv
// Scoreboard bench for mac_frame_engine: generator beats, gaps, backpressure,
// checker counters and mid-frame reset.
module tb_mac_frame_engine;

    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          enable0 = 1'b0;
    logic [15:0]   cfg_len = 16'd46;
    logic [15:0]   cfg_num = 16'd1;
    logic          rx_ready = 1'b1;
    logic          loop_mode = 1'b0;
    logic [DW-1:0] drv_tdata = '0;
    logic [KW-1:0] drv_tkeep = '0;
    logic          drv_tvalid = 1'b0;
    logic          drv_tlast = 1'b0;

    logic [DW-1:0] rx_tdata, tx_tdata, g0_tdata;
    logic [KW-1:0] rx_tkeep, tx_tkeep, g0_tkeep;
    logic          rx_tvalid, rx_tlast, tx_tvalid, tx_tlast, tx_tready, m_ready;
    logic          g0_tvalid, g0_tlast, g0_txr, g0_busy, g0_done;
    logic [31:0]   gen_cnt, chk_cnt, chk_err, g0_gen, g0_chk, g0_err;
    logic          busy, done;

    assign tx_tdata  = loop_mode ? rx_tdata : drv_tdata;
    assign tx_tkeep  = loop_mode ? rx_tkeep : drv_tkeep;
    assign tx_tvalid = loop_mode ? rx_tvalid : drv_tvalid;
    assign tx_tlast  = loop_mode ? rx_tlast : drv_tlast;
    assign m_ready   = loop_mode ? tx_tready : rx_ready;

    mac_frame_engine dut (
        .clk(clk), .reset(rst), .enable(enable),
        .cfg_payload_len(cfg_len), .cfg_num_frames(cfg_num),
        .m_rx_axis_tdata(rx_tdata), .m_rx_axis_tkeep(rx_tkeep),
        .m_rx_axis_tvalid(rx_tvalid), .m_rx_axis_tlast(rx_tlast),
        .m_rx_axis_tready(m_ready),
        .s_tx_axis_tdata(tx_tdata), .s_tx_axis_tkeep(tx_tkeep),
        .s_tx_axis_tvalid(tx_tvalid), .s_tx_axis_tlast(tx_tlast),
        .s_tx_axis_tready(tx_tready),
        .gen_frame_count(gen_cnt), .chk_frame_count(chk_cnt),
        .chk_error_count(chk_err), .busy(busy), .done(done)
    );

    mac_frame_engine #(.FRAME_GAP(0)) dut0 (
        .clk(clk), .reset(rst), .enable(enable0),
        .cfg_payload_len(cfg_len), .cfg_num_frames(cfg_num),
        .m_rx_axis_tdata(g0_tdata), .m_rx_axis_tkeep(g0_tkeep),
        .m_rx_axis_tvalid(g0_tvalid), .m_rx_axis_tlast(g0_tlast),
        .m_rx_axis_tready(1'b1),
        .s_tx_axis_tdata('0), .s_tx_axis_tkeep('0),
        .s_tx_axis_tvalid(1'b0), .s_tx_axis_tlast(1'b0),
        .s_tx_axis_tready(g0_txr),
        .gen_frame_count(g0_gen), .chk_frame_count(g0_chk),
        .chk_error_count(g0_err), .busy(g0_busy), .done(g0_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_gen = 0;
    beat_t       exp_q[$];
    beat_t       seen[$];
    int          gaps[$];
    logic [7:0]  fb[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference frame: dst 00..01, src 00..02, length, payload (j+idx)
    task automatic build_frame(input int p, input int idx);
        logic [15:0] pl;
        pl = 16'(p);
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'h00);
        fb.push_back(8'h01);
        for (int i = 0; i < 5; i++) fb.push_back(8'h00);
        fb.push_back(8'h02);
        fb.push_back(pl[15:8]);
        fb.push_back(pl[7:0]);
        for (int j = 0; j < p; j++) fb.push_back(8'(j + idx));
    endtask

    task automatic push_frame(input int p, input int idx);
        beat_t bt;
        build_frame(p, idx);
        for (int o = 0; o < fb.size(); o += KW) begin
            bt = '0;
            for (int k = 0; k < KW; k++) begin
                if (o + k < fb.size()) begin
                    bt.d[8*k +: 8] = fb[o+k];
                    bt.k[k] = 1'b1;
                end
            end
            bt.l = (o + KW >= fb.size());
            exp_q.push_back(bt);
        end
        exp_gen++;
    endtask

    task automatic send_tx(input int idx, input int corrupt, input int trunc);
        build_frame(46, idx);
        if (corrupt >= 0) fb[corrupt] = fb[corrupt] ^ 8'hFF;
        if (trunc > 0) while (fb.size() > trunc) void'(fb.pop_back());
        for (int o = 0; o < fb.size(); o += KW) begin
            @(posedge clk); #1;
            drv_tdata = '0;
            drv_tkeep = '0;
            for (int k = 0; k < KW; k++) begin
                if (o + k < fb.size()) begin
                    drv_tdata[8*k +: 8] = fb[o+k];
                    drv_tkeep[k] = 1'b1;
                end
            end
            drv_tlast  = (o + KW >= fb.size());
            drv_tvalid = 1'b1;
        end
        @(posedge clk); #1;
        drv_tvalid = 1'b0;
        drv_tlast  = 1'b0;
        @(negedge clk);
    endtask

    task automatic start(input logic [15:0] len, input logic [15:0] num);
        @(posedge clk); #1;
        cfg_len = len;
        cfg_num = num;
        enable  = 1'b1;
    endtask

    task automatic stop();
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_q(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        exp_gen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    beat_t cur, e, hold;
    logic  stall = 1'b0;
    logic  gap_pend = 1'b0;
    int    idle = 0;

    always @(negedge clk) begin
        if (rst) begin
            stall    = 1'b0;
            gap_pend = 1'b0;
        end else begin
            cur = {rx_tdata, rx_tkeep, rx_tlast};
            if (stall) begin
                check("hold_valid", 64'(rx_tvalid), 64'd1);
                check("hold_beat", cur.d, hold.d);
                check("hold_ctl", 64'({cur.k, cur.l}), 64'({hold.k, hold.l}));
            end
            if (!busy) gap_pend = 1'b0;
            if (gap_pend && rx_tvalid) begin
                gaps.push_back(idle);
                gap_pend = 1'b0;
            end else if (gap_pend) begin
                idle++;
            end
            stall = rx_tvalid && !m_ready;
            hold  = cur;
            if (rx_tvalid && m_ready) begin
                seen.push_back(cur);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", cur.d);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", cur.d, e.d);
                    check("rx_ctl", 64'({cur.k, cur.l}), 64'({e.k, e.l}));
                end
                if (cur.l) begin
                    gap_pend = 1'b1;
                    idle     = 0;
                end
            end
        end
    end

    initial begin
        int nv, gapbad, n;
        logic l7;
        logic [63:0] d8, d9;

        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(rx_tvalid), 64'd0);
        check("rst_tdata", rx_tdata, 64'd0);
        check("rst_tkeep", 64'({rx_tkeep, rx_tlast}), 64'd0);
        check("rst_tready", 64'(tx_tready), 64'd0);
        check("rst_counts", 64'(gen_cnt | chk_cnt | chk_err), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 64'(tx_tready), 64'd1);

        seen.delete();
        push_frame(46, 0);
        start(46, 1);
        wait_q(200);
        check("s1_done", 64'({done, busy}), 64'b10);
        check("s1_gen", 64'(gen_cnt), 64'(exp_gen));
        check("s1_beats", 64'(seen.size()), 64'd8);
        check("s1_beat0", seen[0].d, 64'h0000010000000000);
        check("s1_beat1", seen[1].d, 64'h01002E0002000000);
        check("s1_last", 64'({seen[7].k, seen[7].l}), 64'h1F);
        stop();
        check("s1_done_clear", 64'(done), 64'd0);

        push_frame(46, 0);
        start(10, 1);
        wait_q(200);
        stop();
        seen.delete();
        push_frame(1500, 0);
        start(2000, 1);
        wait_q(600);
        check("s2_beats", 64'(seen.size()), 64'd190);
        check("s2_lastkeep", 64'(seen[189].k), 64'h03);
        stop();

        gaps.delete();
        push_frame(46, 0);
        push_frame(46, 1);
        start(46, 2);
        wait_q(300);
        check("s4_gapcount", 64'(gaps.size()), 64'd1);
        if (gaps.size() > 0) check("s4_gap", 64'(gaps[0]), 64'd2);
        check("s4_gen", 64'(gen_cnt), 64'(exp_gen));
        stop();

        seen.delete();
        push_frame(60, 0);
        push_frame(60, 1);
        push_frame(60, 2);
        start(60, 3);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            rx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rx_ready = 1'b1;
        wait_q(100);
        check("s3_f1_byte14", 64'(seen[11].d[55:48]), 64'h01);
        check("s3_gen", 64'(gen_cnt), 64'(exp_gen));
        stop();

        @(posedge clk); #1;
        cfg_len = 16'd46;
        cfg_num = 16'd2;
        enable0 = 1'b1;
        nv = 0;
        gapbad = 0;
        l7 = 1'b0;
        d8 = '0;
        d9 = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (g0_tvalid) begin
                if (nv == 7) l7 = g0_tlast;
                if (nv == 8) d8 = g0_tdata;
                if (nv == 9) d9 = g0_tdata;
                nv++;
            end else if (nv > 0 && nv < 16) begin
                gapbad++;
            end
        end
        check("g0_beats", 64'(nv), 64'd16);
        check("g0_nogap", 64'(gapbad), 64'd0);
        check("g0_last7", 64'(l7), 64'd1);
        check("g0_f1_beat0", d8, 64'h0000010000000000);
        check("g0_f1_beat1", d9, 64'h02012E0002000000);
        check("g0_gen_done", 64'({g0_gen[3:0], g0_done}), 64'h5);
        enable0 = 1'b0;

        do_reset();
        loop_mode = 1'b1;
        for (int f = 0; f < 4; f++) push_frame(46, f);
        start(46, 4);
        wait_q(500);
        check("lb_chk_cnt", 64'(chk_cnt), 64'd4);
        check("lb_chk_err", 64'(chk_err), 64'd0);
        check("lb_gen", 64'(gen_cnt), 64'(exp_gen));
        stop();
        loop_mode = 1'b0;

        do_reset();
        send_tx(0, -1, 0);
        send_tx(1, -1, 0);
        send_tx(2, 20, 0);
        check("corrupt_err", 64'(chk_err), 64'd1);
        send_tx(3, -1, 40);
        check("trunc_cnt", 64'(chk_cnt), 64'd4);
        check("trunc_err", 64'(chk_err), 64'd2);

        seen.delete();
        push_frame(46, 0);
        start(46, 0);
        n = 0;
        while (seen.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(rx_tvalid), 64'd0);
        check("mid_rst_tdata", rx_tdata, 64'd0);
        check("mid_rst_ctl", 64'({rx_tkeep, rx_tlast, busy}), 64'd0);
        check("mid_rst_counts", 64'(gen_cnt | chk_cnt | chk_err), 64'd0);
        exp_q.delete();
        exp_gen = 0;
        @(negedge clk);
        seen.delete();
        push_frame(46, 0);
        rst = 1'b0;
        n = 0;
        while (seen.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        enable = 1'b0;
        wait_q(200);
        @(negedge clk);
        check("post_rst_gen", 64'(gen_cnt), 64'(exp_gen));
        check("post_rst_idle", 64'({busy, rx_tvalid}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_frame_engine.md
Name: mac_frame_engine

Overview:
Parametrised Ethernet frame generator and loopback checker for MAC bring-up on the KC705 board. The generator drives fully AXI-Stream-compliant frames (header plus incrementing payload) on the RX master. The checker consumes frames on the TX slave and compares them against the same pattern. It replaces the fixed 64-bit, single-length test engine and adds:
- configurable width, length, frame count and inter-frame gap
- proper tready backpressure handling
- error and frame counters

Parameters:
DATA_WIDTH, 64, AXIS data width in bits; multiple of 8, 32..512.
KEEP_WIDTH, DATA_WIDTH/8, AXIS keep width.
SRC_MAC, 48'h000000000002, source MAC address inserted in header.
DST_MAC, 48'h000000000001, destination MAC address inserted in header.
MAX_PAYLOAD, 1500, upper clamp on payload bytes.
MIN_PAYLOAD, 46, lower clamp on payload bytes.
FRAME_GAP, 2, idle cycles (tvalid low) between generated frames.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  level; start and continue generation.
cfg_payload_len  in  16  payload bytes; sampled at each frame start and clamped.
cfg_num_frames  in  16  frames per run; 0 = continuous while enable high.
m_rx_axis_tdata  out  DATA_WIDTH  generated frame data; lane 0 = bits[7:0] = earliest byte.
m_rx_axis_tkeep  out  KEEP_WIDTH  byte enables.
m_rx_axis_tvalid  out  1  generator valid.
m_rx_axis_tlast  out  1  last beat of frame.
m_rx_axis_tready  in  1  downstream ready.
s_tx_axis_tdata  in  DATA_WIDTH  frame to check.
s_tx_axis_tkeep  in  KEEP_WIDTH  byte enables.
s_tx_axis_tvalid  in  1  checker input valid.
s_tx_axis_tlast  in  1  checker input last.
s_tx_axis_tready  out  1  checker ready.
gen_frame_count  out  32  frames fully accepted on the RX master.
chk_frame_count  out  32  frames received (tlast beats) on the TX slave.
chk_error_count  out  32  received frames with at least one error.
busy  out  1  generator not in IDLE or DONE.
done  out  1  high in DONE.

Behaviour:
- Reset (async assert, sync release): tvalid=0, tlast=0, tkeep=0, tdata=0, s_tx_axis_tready=0, all counters 0, busy=0, done=0, state=IDLE, frame index=0. s_tx_axis_tready goes 1 on the first clock edge after release and stays 1.
- Frame format, byte i, with P = clamped payload length and L = 14+P:
  - bytes 0-5: DST_MAC MSB first.
  - bytes 6-11: SRC_MAC MSB first.
  - bytes 12-13: P big-endian.
  - byte 14+j: (j + frame_idx)[7:0], where frame_idx = run-relative frame number starting at 0.
- Beats and keep: beats = ceil(L/KEEP_WIDTH). Non-last beats have tkeep all ones. The last beat has the low (L mod KEEP_WIDTH) bits set, or all ones if the remainder is 0. Disabled lanes drive 0.
- Clamp: P < MIN_PAYLOAD → MIN_PAYLOAD; P > MAX_PAYLOAD → MAX_PAYLOAD.
- Generator FSM states: IDLE, SEND, GAP, DONE.
  - IDLE: on an edge with enable=1, latch P, load beat 0 and go to SEND. tvalid is high after that same edge (1-cycle latency).
  - SEND: output registered. Once tvalid=1, tdata/tkeep/tlast hold stable until tvalid&&tready. On accept of a non-last beat, load the next beat on the same edge, giving no bubble under continuous ready.
  - Accept of the last beat: gen_frame_count+1 and frame_idx+1. Next state:
    - DONE if cfg_num_frames≠0 and the run count is reached;
    - IDLE if enable=0;
    - otherwise GAP.
    If FRAME_GAP=0, go directly to SEND with the next frame's beat 0 loaded.
  - GAP: tvalid=0 for exactly FRAME_GAP cycles, then behave as IDLE entry (re-sample enable and P).
  - DONE: tvalid=0, done=1. Go to IDLE when enable=0; a new run restarts frame_idx at 0.
- Enable deassertion mid-frame: the current frame always completes, and tvalid is never dropped before acceptance. The frame length is never changed mid-frame.
- Checker:
  - Tracks its own byte offset and expected frame index. It reads P from received bytes 12-13, with clamping not applied.
  - Frame error conditions:
    - any enabled byte mismatches the expected pattern;
    - a non-last beat has tkeep not all ones;
    - tlast arrives at a byte count ≠ 14+P;
    - the byte count exceeds 14+P without tlast.
  - The error is counted once, at tlast, and chk_frame_count increments at every tlast beat. The expected index advances per tlast even on error.
- Counters wrap at 2^32. Simultaneous generator and checker events are independent.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is abandoned, and the checker offset clears.

Test Plan:
1. DATA_WIDTH=64, P=46, num_frames=1, tready=1 → 8 beats. Beat0 tdata=64'h0000010000000000; beat1 tdata=64'h01002E0002000000; beat7 tkeep=8'h0F with tlast=1; then done=1 and gen_frame_count=1.
2. P=10 → clamped to 46 (same beats as scenario 1). P=2000 → 1514-byte frame; last tkeep=8'h03; 190 beats.
3. Random tready (50%) during a 3-frame run → tdata/tkeep/tlast never change while tvalid&&!tready. Frame 1 byte 14 = 8'h01.
4. FRAME_GAP=2, num_frames=2 → exactly 2 cycles of tvalid=0 between frames. With FRAME_GAP=0, the next beat0 follows the last beat directly.
5. RX looped to TX for 4 frames → chk_frame_count=4, chk_error_count=0. One corrupted payload byte in frame 2 → chk_error_count=1. Early tlast in frame 3 → chk_error_count=2.
6. Reset asserted mid-beat 3 with enable held → outputs 0 asynchronously. After release, the generator restarts at frame_idx 0, beat 0.
